// File: rtl/wb_dual_master_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held per bus
// cycle and a watchdog that answers a never-acknowledged strobe with an error.
module wb_dual_master_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic [DATA_WIDTH-1:0]   m0_data_i,
   output logic [DATA_WIDTH-1:0]   m0_data_o,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,

   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic [DATA_WIDTH-1:0]   m1_data_i,
   output logic [DATA_WIDTH-1:0]   m1_data_o,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,

   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [DATA_WIDTH/8-1:0] s_sel_o,
   output logic [ADDR_WIDTH-1:0]   s_addr_o,
   output logic [DATA_WIDTH-1:0]   s_data_o,
   input  logic [DATA_WIDTH-1:0]   s_data_i,
   input  logic                    s_ack_i,

   output logic [1:0]              grant_o,
   output logic                    timeout_o
);

   localparam bit          WDOG_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      ERR    = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        last_owner;
   logic        owner;
   logic [15:0] wdog_cnt;
   logic        req0;
   logic        req1;
   logic        wdog_hit;

   // Contested requests go to the master that did not own the bus last.
   function automatic state_t arbitrate(input logic r0, input logic r1, input logic last);
      state_t pick;
      if (r0 && r1)  pick = last ? GRANT0 : GRANT1;
      else if (r0)   pick = GRANT0;
      else if (r1)   pick = GRANT1;
      else           pick = IDLE;
      return pick;
   endfunction

   assign req0     = m0_cyc_i & m0_stb_i;
   assign req1     = m1_cyc_i & m1_stb_i;
   assign wdog_hit = WDOG_EN && s_stb_o && !s_ack_i && (wdog_cnt == WDOG_LAST);

   // Releasing cyc re-arbitrates in the same cycle so a waiting master takes over
   // without a dead cycle; a release takes priority over a coincident timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = arbitrate(req0, req1, last_owner);
         GRANT0: begin
            if (!m0_cyc_i)     next_state = arbitrate(req0, req1, 1'b0);
            else if (wdog_hit) next_state = ERR;
         end
         GRANT1: begin
            if (!m1_cyc_i)     next_state = arbitrate(req0, req1, 1'b1);
            else if (wdog_hit) next_state = ERR;
         end
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: every register here uses <= so all of them see the same pre-edge
   // values of state and wdog_cnt, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         owner      <= 1'b0;
         wdog_cnt   <= 16'd0;
         grant_o    <= 2'b00;
         timeout_o  <= 1'b0;
      end else begin
         state   <= next_state;
         grant_o <= {next_state == GRANT1, next_state == GRANT0};

         case (state)
            GRANT0:  if (!m0_cyc_i) last_owner <= 1'b0;
            GRANT1:  if (!m1_cyc_i) last_owner <= 1'b1;
            ERR:     last_owner <= owner;
            default: ;
         endcase

         if (next_state == GRANT0)      owner <= 1'b0;
         else if (next_state == GRANT1) owner <= 1'b1;

         if (next_state == ERR) timeout_o <= 1'b1;

         // Counts only consecutive unacknowledged strobes within one ownership.
         if (WDOG_EN && (next_state == state) && s_stb_o && !s_ack_i)
            wdog_cnt <= wdog_cnt + 16'd1;
         else
            wdog_cnt <= 16'd0;
      end
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_addr_o  = '0;
      s_data_o  = '0;
      m0_data_o = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_data_o = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      case (state)
         GRANT0: begin
            s_cyc_o   = m0_cyc_i;
            s_stb_o   = m0_stb_i;
            s_we_o    = m0_we_i;
            s_sel_o   = m0_sel_i;
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            m0_data_o = s_data_i;
            m0_ack_o  = s_ack_i;
         end
         GRANT1: begin
            s_cyc_o   = m1_cyc_i;
            s_stb_o   = m1_stb_i;
            s_we_o    = m1_we_i;
            s_sel_o   = m1_sel_i;
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            m1_data_o = s_data_i;
            m1_ack_o  = s_ack_i;
         end
         ERR: begin
            m0_err_o = !owner;
            m1_err_o = owner;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: a cycle-by-cycle vector table for
// arbitration and bursts, plus hand-written timeout, boundary and reset sequences.
module tb_wb_dual_master_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   localparam logic [31:0] M0_ADDR = 32'h0000_0100;
   localparam logic [31:0] M1_ADDR = 32'h0000_0200;
   localparam logic [31:0] M0_WDAT = 32'h1111_2222;
   localparam logic [31:0] M1_WDAT = 32'hA5A5_0001;
   localparam logic [3:0]  M0_SEL  = 4'hF;
   localparam logic [3:0]  M1_SEL  = 4'h3;
   localparam logic [31:0] S_RDAT  = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]    m0_sel_i;
   logic [AW-1:0] m0_addr_i;
   logic [DW-1:0] m0_data_i, m0_data_o;
   logic          m0_ack_o, m0_err_o;
   logic          m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]    m1_sel_i;
   logic [AW-1:0] m1_addr_i;
   logic [DW-1:0] m1_data_i, m1_data_o;
   logic          m1_ack_o, m1_err_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]    s_sel_o;
   logic [AW-1:0] s_addr_o;
   logic [DW-1:0] s_data_o, s_data_i;
   logic          s_ack_i;
   logic [1:0]    grant_o;
   logic          timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_dual_master_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   typedef struct {
      logic       rst_n;
      logic       c0, s0, c1, s1, ack;
      logic [1:0] grant;
      logic       scyc, sstb, ack0, ack1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic c0, input logic s0,
                               input logic c1, input logic s1, input logic ack,
                               input logic [1:0] g, input logic sc, input logic ss,
                               input logic a0, input logic a1);
      vec_t v;
      v.rst_n = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
      v.grant = g; v.scyc = sc; v.sstb = ss; v.ack0 = a0; v.ack1 = a1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      s_ack_i  = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   // Checks every output against the values implied by an expected owner.
   task automatic check_vec(input int i, input vec_t v);
      logic [31:0] e_addr, e_wdat;
      logic [3:0]  e_sel;
      logic        e_we;
      e_addr = (v.grant == 2'b01) ? M0_ADDR : (v.grant == 2'b10) ? M1_ADDR : 32'd0;
      e_wdat = (v.grant == 2'b01) ? M0_WDAT : (v.grant == 2'b10) ? M1_WDAT : 32'd0;
      e_sel  = (v.grant == 2'b01) ? M0_SEL  : (v.grant == 2'b10) ? M1_SEL  : 4'h0;
      e_we   = (v.grant == 2'b10);
      check($sformatf("v%0d grant", i), 32'(grant_o), 32'(v.grant));
      check($sformatf("v%0d s_cyc", i), 32'(s_cyc_o), 32'(v.scyc));
      check($sformatf("v%0d s_stb", i), 32'(s_stb_o), 32'(v.sstb));
      check($sformatf("v%0d s_we", i), 32'(s_we_o), 32'(e_we));
      check($sformatf("v%0d s_sel", i), 32'(s_sel_o), 32'(e_sel));
      check($sformatf("v%0d s_addr", i), s_addr_o, e_addr);
      check($sformatf("v%0d s_data", i), s_data_o, e_wdat);
      check($sformatf("v%0d m0_ack", i), 32'(m0_ack_o), 32'(v.ack0));
      check($sformatf("v%0d m1_ack", i), 32'(m1_ack_o), 32'(v.ack1));
      check($sformatf("v%0d m0_data", i), m0_data_o, v.grant[0] ? S_RDAT : 32'd0);
      check($sformatf("v%0d m1_data", i), m1_data_o, v.grant[1] ? S_RDAT : 32'd0);
      check($sformatf("v%0d m0_err", i), 32'(m0_err_o), 32'd0);
      check($sformatf("v%0d m1_err", i), 32'(m1_err_o), 32'd0);
      check($sformatf("v%0d timeout", i), 32'(timeout_o), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      m0_cyc_i  = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = M0_SEL;
      m0_addr_i = M0_ADDR; m0_data_i = M0_WDAT;
      m1_cyc_i  = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b1; m1_sel_i = M1_SEL;
      m1_addr_i = M1_ADDR; m1_data_i = M1_WDAT;
      s_data_i  = S_RDAT;
      s_ack_i   = 1'b0;

      //                 rst c0 s0 c1 s1 ack grant  scyc sstb a0 a1
      // Single read by m0, acked on the second slave cycle.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      // Round-robin from reset: m0, m1, m0, m1 with zero-gap handovers.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 0, 2'b10, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 1, 1, 2'b10, 1, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      // Locked m1 write burst with a 2-cycle strobe gap; m0 waits throughout.
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));

      next_cycle();
      foreach (vecs[i]) begin
         rst_n    = vecs[i].rst_n;
         m0_cyc_i = vecs[i].c0;  m0_stb_i = vecs[i].s0;
         m1_cyc_i = vecs[i].c1;  m1_stb_i = vecs[i].s1;
         s_ack_i  = vecs[i].ack;
         @(negedge clk);
         check_vec(i, vecs[i]);
         next_cycle();
      end

      // Reset while m1 waits: outputs clear without a clock edge, and the reset
      // last_owner (m1) makes m0 win the next contested arbitration.
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      next_cycle();
      @(negedge clk);
      check("rst grant before", 32'(grant_o), 32'(2'b10));
      check("rst s_cyc before", 32'(s_cyc_o), 32'd1);
      #1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst async grant", 32'(grant_o), 32'd0);
      check("rst async s_cyc", 32'(s_cyc_o), 32'd0);
      check("rst async s_stb", 32'(s_stb_o), 32'd0);
      check("rst async s_addr", s_addr_o, 32'd0);
      check("rst async m1_ack", 32'(m1_ack_o), 32'd0);
      check("rst async m1_data", m1_data_o, 32'd0);
      next_cycle();
      rst_n = 1'b1; s_ack_i = 1'b0;
      @(negedge clk);
      check("rst idle grant", 32'(grant_o), 32'd0);
      next_cycle();
      @(negedge clk);
      check("rst first contested grant", 32'(grant_o), 32'(2'b01));
      check("rst first contested s_addr", s_addr_o, M0_ADDR);

      // Watchdog: m1 read never acked, error after 8 strobe cycles.
      m1_we_i = 1'b0;
      do_reset();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      next_cycle();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("to wait%0d m1_err", k), 32'(m1_err_o), 32'd0);
         check($sformatf("to wait%0d s_stb", k), 32'(s_stb_o), 32'd1);
         check($sformatf("to wait%0d timeout", k), 32'(timeout_o), 32'd0);
         next_cycle();
      end
      s_ack_i = 1'b1;
      @(negedge clk);
      check("to err m1_err", 32'(m1_err_o), 32'd1);
      check("to err m0_err", 32'(m0_err_o), 32'd0);
      check("to err m1_ack", 32'(m1_ack_o), 32'd0);
      check("to err s_cyc", 32'(s_cyc_o), 32'd0);
      check("to err s_stb", 32'(s_stb_o), 32'd0);
      check("to err timeout", 32'(timeout_o), 32'd1);
      next_cycle();
      s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      @(negedge clk);
      check("to after m1_err", 32'(m1_err_o), 32'd0);
      check("to after grant", 32'(grant_o), 32'd0);
      check("to after timeout", 32'(timeout_o), 32'd1);
      next_cycle();
      @(negedge clk);
      check("to sticky timeout", 32'(timeout_o), 32'd1);
      next_cycle();

      // Boundary: ack on the 8th strobe cycle wins over the watchdog.
      do_reset();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      next_cycle();
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("bd wait%0d m1_ack", k), 32'(m1_ack_o), 32'd0);
         next_cycle();
      end
      s_ack_i = 1'b1;
      @(negedge clk);
      check("bd ack8 m1_ack", 32'(m1_ack_o), 32'd1);
      check("bd ack8 m1_data", m1_data_o, S_RDAT);
      check("bd ack8 m1_err", 32'(m1_err_o), 32'd0);
      next_cycle();
      s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      @(negedge clk);
      check("bd release m1_err", 32'(m1_err_o), 32'd0);
      check("bd release grant", 32'(grant_o), 32'(2'b10));
      next_cycle();
      @(negedge clk);
      check("bd idle grant", 32'(grant_o), 32'd0);
      check("bd idle timeout", 32'(timeout_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
